// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply/divide unit producing HI/LO results.
// One radix-2 step per clock: shift-add for MULTU/MULT, restoring
// shift-subtract for DIVU/DIV, both on operand magnitudes. A final
// FIX cycle applies sign correction and loads hi/lo.
// Ports:
//   clk, rst (async, active low)
//   start, op[1:0], src_a, src_b  - request and operands
//   busy, done                    - status (done is a one-cycle pulse)
//   hi, lo                        - result registers
//   div_by_zero                   - sticky until the next accepted start
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic             accept_c;

  logic [CW-1:0]    count;
  logic             div_q;
  logic             neg_a_q;
  logic             neg_b_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] mag_a_q;
  logic [WIDTH-1:0] mag_b_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             in_neg_a_c;
  logic             in_neg_b_c;
  logic [WIDTH-1:0] in_mag_a_c;
  logic [WIDTH-1:0] in_mag_b_c;

  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   div_shift_c;
  logic             div_ge_c;
  logic [WIDTH-1:0] div_sub_c;

  logic             zero_b_c;
  logic [WIDTH-1:0] fix_hi_c;
  logic [WIDTH-1:0] fix_lo_c;

  // Operand magnitudes at acceptance; op[0] selects signed interpretation.
  assign in_neg_a_c = op[0] & src_a[WIDTH-1];
  assign in_neg_b_c = op[0] & src_b[WIDTH-1];
  assign in_mag_a_c = in_neg_a_c ? (~src_a + WIDTH'(1)) : src_a;
  assign in_mag_b_c = in_neg_b_c ? (~src_b + WIDTH'(1)) : src_b;

  // Multiply step: conditionally add the multiplicand, then shift {acc_hi,acc_lo} right.
  assign mul_sum_c = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a_q} : '0);

  // Divide step: shift the next dividend bit into the partial remainder and trial-subtract.
  // When the trial succeeds the difference is below the divisor, so WIDTH bits suffice.
  assign div_shift_c = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge_c    = (div_shift_c >= {1'b0, mag_b_q});
  assign div_sub_c   = div_shift_c[WIDTH-1:0] - mag_b_q;

  assign zero_b_c = (mag_b_q == '0);

  // Sign correction applied in FIX.
  always_comb begin
    fix_hi_c = acc_hi;
    fix_lo_c = acc_lo;
    if (div_q) begin
      if (zero_b_c) begin
        fix_hi_c = a_q;
        fix_lo_c = '1;
      end else begin
        if (neg_a_q ^ neg_b_q) fix_lo_c = ~acc_lo + WIDTH'(1);
        if (neg_a_q)           fix_hi_c = ~acc_hi + WIDTH'(1);
      end
    end else if (neg_a_q ^ neg_b_q) begin
      {fix_hi_c, fix_lo_c} = ~{acc_hi, acc_lo} + PW'(1);
    end
  end

  // Next-state logic. DONE also accepts a start so the edge leaving DONE can launch a new op.
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = CALC;
          accept_c   = 1'b1;
        end
      end
      CALC: begin
        if (count == CW'(WIDTH - 1)) next_state = FIX;
      end
      FIX: begin
        next_state = DONE;
      end
      DONE: begin
        if (start) begin
          next_state = CALC;
          accept_c   = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);
    end
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      div_q       <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      a_q         <= '0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (accept_c) begin
      count       <= '0;
      div_q       <= op[1];
      neg_a_q     <= in_neg_a_c;
      neg_b_q     <= in_neg_b_c;
      a_q         <= src_a;
      mag_a_q     <= in_mag_a_c;
      mag_b_q     <= in_mag_b_c;
      acc_hi      <= '0;
      acc_lo      <= op[1] ? in_mag_a_c : in_mag_b_c;
      div_by_zero <= 1'b0;
    end else if (state == CALC) begin
      count <= count + CW'(1);
      if (div_q) begin
        acc_hi <= div_ge_c ? div_sub_c : div_shift_c[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], div_ge_c};
      end else begin
        acc_hi <= mul_sum_c[WIDTH:1];
        acc_lo <= {mul_sum_c[0], acc_lo[WIDTH-1:1]};
      end
    end else if (state == FIX) begin
      hi          <= fix_hi_c;
      lo          <= fix_lo_c;
      div_by_zero <= div_q & zero_b_c;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed literal cases plus
// randomized operations compared cycle by cycle against a timeline model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference result {div_by_zero, hi, lo} from plain arithmetic.
  function automatic logic [64:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin pu = 64'(a) * 64'(b); return {1'b0, pu}; end
      2'b01: begin q = sa * sb; return {1'b0, 64'(q)}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, 32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Timeline model: an accepted op completes 33 edges later and the unit frees one edge after.
  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [64:0] m_res = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dbz = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_hi     <= '0;
      m_lo     <= '0;
      m_dbz    <= 1'b0;
    end else if (start && (!m_active || m_k == 33)) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_dbz    <= 1'b0;
      m_res    <= ref_res(op, src_a, src_b);
    end else if (m_active) begin
      m_k <= m_k + 1;
      if (m_k == 32) begin
        m_dbz <= m_res[64];
        m_hi  <= m_res[63:32];
        m_lo  <= m_res[31:0];
      end
      if (m_k == 33) m_active <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_active && m_k == 33));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Launch one op and wait for done; inj>0 pulses a stray start at that busy cycle.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input int inj, input bit no_wait);
    int n;
    if (!no_wait) @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({nm, " busy_after_accept"}, 32'(busy), 32'd1);
    check({nm, " dbz_cleared"}, 32'(div_by_zero), 32'd0);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      start = (n == inj);
      if (n == inj) begin
        op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      end
    end
    start = 1'b0;
    check({nm, " latency"}, 32'(n), 32'd34);
    check({nm, " hi"}, hi, eh);
    check({nm, " lo"}, lo, el);
    check({nm, " dbz"}, 32'(div_by_zero), 32'(ed));
  endtask

  initial begin
    logic [64:0] r;
    logic [1:0]  o;
    logic [31:0] a, b;
    int          seen;

    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    chk_en = 1'b1;
    rst = 1'b1;

    // Start on the first edge after reset release.
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 1'b1);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 1'b0);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 1'b0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 1'b0);
    run_op("divu_by0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0, 1'b0);
    run_op("mult_ignore", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 5, 1'b0);
    // Start presented while done is high is taken on the edge leaving DONE.
    run_op("b2b", 2'b10, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 0, 1'b1);
    run_op("mul_by0", 2'b01, 32'hFFFF_FFF1, 32'd0, 32'd0, 32'd0, 1'b0, 0, 1'b1);

    // Abort with reset during an operation.
    @(negedge clk);
    op = 2'b00; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort no_done", 32'(seen), 32'd0);

    // Randomized operations, some with stray starts while busy.
    for (int i = 0; i < 180; i++) begin
      o = 2'($urandom);
      a = pick();
      b = pick();
      r = ref_res(o, a, b);
      run_op("rand", o, a, b, r[63:32], r[31:0], r[64],
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0,
             bit'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
